// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin Avalon-MM arbiter/sequencer in front of a single-port on-chip RAM.
// Define ONCHIP_MEM_ARB_CLEAR_EN to compile in the whole-RAM clear engine (CLEAR/DONE states).
module onchip_mem_arbiter #(
    parameter int unsigned DEPTH = 45000,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,

    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,

    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata,

    input  logic              clr_start,
    input  logic [DW-1:0]     clr_value,
    output logic              clr_busy,
    output logic              clr_done
);

    logic            req0, req1;
    logic            grant0, grant1;
    logic            in_idle, in_clear, in_done;
    logic [AW-1:0]   cnt_q;
    logic [DW-1:0]   clr_val_q;

    logic            last_q, last_d;
    logic            rd_pend_q, rd_pend_d;
    logic            rd_owner_q, rd_owner_d;

    // last_q = 1 means m1 was granted most recently, so m0 wins the next tie.
    always_comb begin
        req0   = m0_read | m0_write;
        req1   = m1_read | m1_write;
        grant0 = reset_n & in_idle & req0 & (~req1 | last_q);
        grant1 = reset_n & in_idle & req1 & (~req0 | ~last_q);
    end

    always_comb begin
        last_d     = last_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (grant0) begin
            last_d     = 1'b0;
            rd_pend_d  = ~m0_write;
            rd_owner_d = 1'b0;
        end else if (grant1) begin
            last_d     = 1'b1;
            rd_pend_d  = ~m1_write;
            rd_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (in_clear) begin
            mem_address    = cnt_q;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = clr_val_q;
        end else if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    // RAM output is unregistered, so read data is steered straight from mem_readdata.
    always_comb begin
        m0_readdatavalid = rd_pend_q & ~rd_owner_q;
        m1_readdatavalid = rd_pend_q &  rd_owner_q;
        m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
        m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
        m0_waitrequest   = ~grant0;
        m1_waitrequest   = ~grant1;
        mem_clken        = 1'b1;
    end

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_CLEAR = 2'd1;
    localparam logic [1:0]    ST_DONE  = 2'd2;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_d;
    logic [DW-1:0] clr_val_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_val_d = clr_val_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    clr_val_d = clr_value;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clr_val_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_val_q <= clr_val_d;
        end
    end

    assign in_idle  = (state_q == ST_IDLE);
    assign in_clear = (state_q == ST_CLEAR);
    assign in_done  = (state_q == ST_DONE);
    assign clr_busy = in_clear | in_done;
    assign clr_done = in_done;
`else
    logic unused_clr;

    assign in_idle    = 1'b1;
    assign in_clear   = 1'b0;
    assign in_done    = 1'b0;
    assign cnt_q      = '0;
    assign clr_val_q  = '0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign unused_clr = ^{clr_start, clr_value, DEPTH};
`endif

endmodule
